// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the execute stage and the iterative mult/div unit.
// Any module driving the request side connects through the master modport.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo, wr_data,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fix-up on the last cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_div_unit_if.slave       bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]       acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]       rs_raw_q, rs_raw_d;
  logic                   prod_neg_q, prod_neg_d;
  logic                   rem_neg_q, rem_neg_d;
  logic                   div0_q, div0_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   rs_neg, rt_neg;
  logic [WIDTH-1:0]       rs_mag, rt_mag;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH:0]         div_diff;
  logic [2*WIDTH-1:0]     product;

  // Next-state, datapath step and result write-back
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    rs_raw_d   = rs_raw_q;
    prod_neg_d = prod_neg_q;
    rem_neg_d  = rem_neg_q;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;

    rs_neg    = ~bus.op[0] & bus.rs_val[WIDTH-1];
    rt_neg    = ~bus.op[0] & bus.rt_val[WIDTH-1];
    rs_mag    = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag    = rt_neg ? -bus.rt_val : bus.rt_val;
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, a_q};
    product   = {acc_hi_q, acc_lo_q};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          cnt_d      = '0;
          op_d       = bus.op;
          acc_hi_d   = '0;
          rs_raw_d   = bus.rs_val;
          prod_neg_d = rs_neg ^ rt_neg;
          rem_neg_d  = rs_neg;
          div0_d     = (bus.rt_val == '0);
          // Divide: dividend shifts out of acc_lo; multiply: multiplier does.
          a_d        = bus.op[1] ? rt_mag : rs_mag;
          acc_lo_d   = bus.op[1] ? rs_mag : rt_mag;
        end else begin
          if (bus.mthi) hi_d = bus.wr_data;
          if (bus.mtlo) lo_d = bus.wr_data;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q[1]) begin
          if (div_diff[WIDTH]) begin
            acc_hi_d = div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_hi_d = div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        if (op_q[1]) begin
          if (div0_q) begin
            lo_d = '1;
            hi_d = rs_raw_q;
          end else begin
            lo_d = prod_neg_q ? -acc_lo_q : acc_lo_q;
            hi_d = rem_neg_q  ? -acc_hi_q : acc_hi_q;
          end
        end else begin
          if (prod_neg_q) product = -product;
          hi_d = product[2*WIDTH-1:WIDTH];
          lo_d = product[WIDTH-1:0];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      a_q        <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      rs_raw_q   <= '0;
      prod_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      a_q        <= a_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      rs_raw_q   <= rs_raw_d;
      prod_neg_q <= prod_neg_d;
      rem_neg_q  <= rem_neg_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, hand sequences for ignored
// requests and mid-operation reset, then random ops against an arithmetic model.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic and the ISA corner rules
  function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
    longint      sp;
    logic [63:0] up;
    int          sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    h  = '0;
    l  = '0;
    case (op)
      2'b00: begin
        sp = longint'(sa) * longint'(sb);
        {h, l} = 64'(sp);
      end
      2'b01: begin
        up = {32'h0, a} * {32'h0, b};
        {h, l} = up;
      end
      2'b10: begin
        if (b == 32'h0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'h0;
        end else begin
          l = 32'(sa / sb); h = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 32'h0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  // Sample after each edge until busy drops (bounded)
  task automatic wait_not_busy(output int cyc);
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // Issue one op at the next falling edge and check latency, hold, done and result
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    int          cyc;
    logic [31:0] old_hi, old_lo;
    bit          hold_ok;
    @(negedge clk);
    old_hi = bus.hi;
    old_lo = bus.lo;
    bus.start = 1'b1; bus.op = op; bus.rs_val = a; bus.rt_val = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, " busy_after_start"}, 32'(bus.busy), 32'd1);
    check({tag, " done_low_at_start"}, 32'(bus.done), 32'd0);
    cyc = 1;
    hold_ok = 1'b1;
    while (bus.busy === 1'b1 && cyc < 100) begin
      if (bus.hi !== old_hi || bus.lo !== old_lo || bus.done !== 1'b0) hold_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " busy_cycles"}, 32'(cyc - 1), 32'd33);
    check({tag, " hold_during_run"}, 32'(hold_ok), 32'd1);
    check({tag, " done_pulse"}, 32'(bus.done), 32'd1);
    check({tag, " hi"}, bus.hi, eh);
    check({tag, " lo"}, bus.lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int          cyc;
    bit          done_seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb, rh, rl;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{2'b00, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 32'h0000_0019};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{2'b11, 32'h0000_0019, 32'h0000_0003, 32'h0000_0001, 32'h0000_0008};
    vecs[5] = '{2'b10, 32'h0000_000A, 32'h0000_0000, 32'h0000_000A, 32'hFFFF_FFFF};
    vecs[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs_val = '0; bus.rt_val = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset hi", bus.hi, 32'h0);
    check("reset lo", bus.lo, 32'h0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Consecutive table entries start at the first idle edge (back-to-back)
    for (int i = 0; i < 10; i++)
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(bus.done), 32'd0);

    // start and mthi during RUN are both ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd3; bus.rt_val = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'd9; bus.rt_val = 32'd3;
    bus.mthi = 1'b1; bus.wr_data = 32'h1234;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mthi = 1'b0;
    wait_not_busy(cyc);
    check("ignore latency", 32'(cyc), 32'd28);
    check("ignore done", 32'(bus.done), 32'd1);
    check("ignore hi", bus.hi, 32'h0);
    check("ignore lo", bus.lo, 32'd15);

    // mtlo alone in idle, then mthi+mtlo together
    @(negedge clk);
    bus.mtlo = 1'b1; bus.wr_data = 32'd28;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    check("mtlo lo", bus.lo, 32'd28);
    check("mtlo hi_kept", bus.hi, 32'h0);
    @(negedge clk);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wr_data = 32'hA5A5;
    @(posedge clk); #1;
    bus.mthi = 1'b0; bus.mtlo = 1'b0;
    check("mthilo hi", bus.hi, 32'hA5A5);
    check("mthilo lo", bus.lo, 32'hA5A5);

    // Reset during a DIVU clears everything immediately and suppresses done
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.rs_val = 32'h1000; bus.rt_val = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort hi", bus.hi, 32'h0);
    check("abort lo", bus.lo, 32'h0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
    end
    check("abort no_done", 32'(done_seen), 32'd0);
    run_op(2'b01, 32'd10, 32'd2, 32'h0, 32'd20, "post_reset");

    // Random ops against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      ref_model(rop, ra, rb, rh, rl);
      run_op(rop, ra, rb, rh, rl, $sformatf("rnd%0d op%0d %h %h", i, rop, ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
